// File: rtl/led_chase_if.sv
// Board-side signal bundle for the LED chase sequencer: enable, rate switch and mode in; LED bar, toggle pin and step pulse out.
interface led_chase_if #(
  parameter int NLED = 8
);
  logic            enable;
  logic            switch;
  logic [1:0]      mode;
  logic [NLED-1:0] led;
  logic            outpin;
  logic            step;

  modport master (
    output enable, switch, mode,
    input  led, outpin, step
  );

  modport slave (
    input  enable, switch, mode,
    output led, outpin, step
  );
endinterface

// File: rtl/led_chase_sequencer.sv
// Step scheduler for the LED wheel bar: rate divider, display FSM (off/chase/blink/ping-pong), LED and toggle-pin drive.
// Optional switch debouncer enabled by defining DEBOUNCE_EN.
module led_chase_sequencer #(
  parameter int NLED       = 8,
  parameter int FAST_DIV   = 100000,
  parameter int SLOW_DIV   = 10000000,
  parameter int DEB_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  led_chase_if.slave  bus
);

  localparam int CW = $clog2(SLOW_DIV);
  localparam int PW = $clog2(NLED);

  localparam logic [CW-1:0]   FAST_LAST = CW'(FAST_DIV - 1);
  localparam logic [CW-1:0]   SLOW_LAST = CW'(SLOW_DIV - 1);
  localparam logic [PW-1:0]   LAST_POS  = PW'(NLED - 1);
  localparam logic [NLED-1:0] LED_POS0  = NLED'(1);

  if (NLED < 2 || FAST_DIV < 2 || SLOW_DIV < FAST_DIV || DEB_CYCLES < 1) begin : g_bad_params
    $error("led_chase_sequencer: invalid parameter set");
  end

  typedef enum logic {ST_IDLE, ST_RUN} state_e;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_CHASE = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PING  = 2'b11
  } mode_e;

  state_e          state_q, state_d;
  dir_e            dir_q,   dir_d;
  mode_e           mode_q,  mode_d;
  logic [CW-1:0]   ctr_q,   ctr_d;
  logic [PW-1:0]   pos_q,   pos_d;
  logic [NLED-1:0] led_q,   led_d;
  logic            out_q,   out_d;
  logic            step_q,  step_d;
  logic            fast_q,  fast_d;

  // Two-flop synchroniser for the asynchronous rate switch pad.
  logic sw_meta_q, sw_s_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_q <= 1'b0;
      sw_s_q    <= 1'b0;
    end else begin
      sw_meta_q <= bus.switch;
      sw_s_q    <= sw_meta_q;
    end
  end

  logic rate_sel;

`ifdef DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);

  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          rate_q,    rate_d;

  // Counts consecutive cycles the synchronised switch disagrees with the accepted rate; any agreement restarts it.
  always_comb begin
    deb_cnt_d = '0;
    rate_d    = rate_q;
    if (sw_s_q != rate_q) begin
      if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
        rate_d = sw_s_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt_q <= '0;
      rate_q    <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      rate_q    <= rate_d;
    end
  end

  assign rate_sel = rate_q;
`else
  assign rate_sel = sw_s_q;
`endif

  logic [CW-1:0] ctr_last;
  assign ctr_last = fast_q ? FAST_LAST : SLOW_LAST;

  // NOTE: every signal driven here gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    ctr_d   = ctr_q;
    pos_d   = pos_q;
    led_d   = led_q;
    out_d   = out_q;
    step_d  = 1'b0;
    fast_d  = fast_q;

    unique case (state_q)
      ST_IDLE: begin
        // Display state is forgotten while idle, so re-enabling always starts the pattern from its entry value.
        ctr_d  = '0;
        pos_d  = '0;
        dir_d  = DIR_UP;
        led_d  = '0;
        mode_d = MODE_OFF;
        if (bus.enable) state_d = ST_RUN;
      end

      ST_RUN: begin
        if (!bus.enable) begin
          // Idle wins over a coincident step boundary: no pulse, no toggle.
          state_d = ST_IDLE;
          ctr_d   = '0;
          pos_d   = '0;
          dir_d   = DIR_UP;
          led_d   = '0;
          mode_d  = MODE_OFF;
        end else if (ctr_q == ctr_last) begin
          ctr_d  = '0;
          step_d = 1'b1;
          out_d  = ~out_q;
          fast_d = rate_sel;
          mode_d = mode_e'(bus.mode);
          if (mode_d != mode_q) begin
            pos_d = '0;
            dir_d = DIR_UP;
            unique case (mode_d)
              MODE_OFF:   led_d = '0;
              MODE_BLINK: led_d = '1;
              default:    led_d = LED_POS0;
            endcase
          end else begin
            unique case (mode_q)
              MODE_OFF: led_d = '0;
              MODE_CHASE: begin
                pos_d = (pos_q == LAST_POS) ? '0 : pos_q + 1'b1;
                led_d = LED_POS0 << pos_d;
              end
              MODE_BLINK: led_d = (led_q == '0) ? '1 : '0;
              MODE_PING: begin
                // Direction flips as the position leaves an end, so each end is shown exactly once.
                if (dir_q == DIR_UP) begin
                  if (pos_q == LAST_POS) begin
                    pos_d = pos_q - 1'b1;
                    dir_d = DIR_DOWN;
                  end else begin
                    pos_d = pos_q + 1'b1;
                  end
                end else begin
                  if (pos_q == '0) begin
                    pos_d = pos_q + 1'b1;
                    dir_d = DIR_UP;
                  end else begin
                    pos_d = pos_q - 1'b1;
                  end
                end
                led_d = LED_POS0 << pos_d;
              end
              default: led_d = '0;
            endcase
          end
        end else begin
          ctr_d = ctr_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      mode_q  <= MODE_OFF;
      ctr_q   <= '0;
      pos_q   <= '0;
      led_q   <= '0;
      out_q   <= 1'b0;
      step_q  <= 1'b0;
      fast_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      ctr_q   <= ctr_d;
      pos_q   <= pos_d;
      led_q   <= led_d;
      out_q   <= out_d;
      step_q  <= step_d;
      fast_q  <= fast_d;
    end
  end

  assign bus.led    = led_q;
  assign bus.outpin = out_q;
  assign bus.step   = step_q;

endmodule
